// File: rtl/noc_switch_allocator_if.sv
// Handshake bundle between the input routers, the switch allocator
// and the crossbar.
interface noc_switch_allocator_if #(
  parameter int N_PORTS = 5
) ();
  logic [N_PORTS-1:0]         in_valid_i;
  logic [N_PORTS-1:0]         in_head_i;
  logic [N_PORTS-1:0]         in_tail_i;
  logic [N_PORTS*N_PORTS-1:0] in_port_i;
  logic [N_PORTS-1:0]         in_ready_o;
  logic [N_PORTS-1:0]         out_valid_o;
  logic [N_PORTS-1:0]         out_ready_i;
  logic [N_PORTS*N_PORTS-1:0] out_sel_o;
  logic [N_PORTS-1:0]         out_tail_o;

  modport master (
    output in_valid_i,
    output in_head_i,
    output in_tail_i,
    output in_port_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_sel_o,
    input  out_tail_o
  );

  modport slave (
    input  in_valid_i,
    input  in_head_i,
    input  in_tail_i,
    input  in_port_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_sel_o,
    output out_tail_o
  );
endinterface

// File: rtl/noc_switch_allocator.sv
// Per-output round-robin switch allocator with packet locking
// (head to tail) and crossbar select generation.
module noc_switch_allocator #(
  parameter int N_PORTS = 5
) (
  input  logic                  clk,
  input  logic                  arst,
  noc_switch_allocator_if.slave bus
);
  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e        state_q [N_PORTS];
  state_e        state_d [N_PORTS];
  logic [IW-1:0] owner_q [N_PORTS];
  logic [IW-1:0] owner_d [N_PORTS];
  logic [IW-1:0] ptr_q   [N_PORTS];
  logic [IW-1:0] ptr_d   [N_PORTS];

  logic [N_PORTS-1:0] dec_vld;
  logic [IW-1:0]      dec_idx [N_PORTS];
  logic [N_PORTS-1:0] owned;
  logic [N_PORTS-1:0] req     [N_PORTS];
  logic [N_PORTS-1:0] claimed;
  logic               found;
  int                 gidx;
  int                 idx;

  logic [N_PORTS-1:0]         in_ready;
  logic [N_PORTS-1:0]         out_valid;
  logic [N_PORTS-1:0]         out_tail;
  logic [N_PORTS*N_PORTS-1:0] out_sel;

  // Lowest set bit of each destination vector wins
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      dec_vld[i] = 1'b0;
      dec_idx[i] = '0;
      for (int j = N_PORTS - 1; j >= 0; j--) begin
        if (bus.in_port_i[i*N_PORTS + j]) begin
          dec_vld[i] = 1'b1;
          dec_idx[i] = IW'(j);
        end
      end
    end
  end

  always_comb begin
    owned = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      if (state_q[o] == LOCKED) begin
        owned[owner_q[o]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        req[o][i] = bus.in_valid_i[i]
                  & bus.in_head_i[i]
                  & dec_vld[i]
                  & (dec_idx[i] == IW'(o))
                  & ~owned[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int o = 0; o < N_PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  // Lower output indices claim first, so a doubly-requested input
  // is only ever granted once
  always_comb begin
    claimed = '0;
    found   = 1'b0;
    gidx    = 0;
    idx     = 0;
    for (int o = 0; o < N_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      found      = 1'b0;
      gidx       = 0;
      unique case (state_q[o])
        IDLE: begin
          for (int k = 0; k < N_PORTS; k++) begin
            idx = (int'(ptr_q[o]) + k) % N_PORTS;
            if (!found && req[o][idx] && !claimed[idx]) begin
              found = 1'b1;
              gidx  = idx;
            end
          end
          if (found) begin
            claimed[gidx] = 1'b1;
            state_d[o]    = LOCKED;
            owner_d[o]    = IW'(gidx);
            ptr_d[o]      = IW'((gidx + 1) % N_PORTS);
          end
        end
        LOCKED: begin
          if (bus.in_valid_i[owner_q[o]]
              && bus.out_ready_i[o]
              && bus.in_tail_i[owner_q[o]]) begin
            state_d[o] = IDLE;
          end
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = '0;
    out_valid = '0;
    out_tail  = '0;
    out_sel   = '0;
    if (!arst) begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (state_q[o] == LOCKED) begin
          out_sel[o*N_PORTS + int'(owner_q[o])] = 1'b1;
          out_valid[o]       = bus.in_valid_i[owner_q[o]];
          out_tail[o]        = bus.in_tail_i[owner_q[o]];
          in_ready[owner_q[o]] = bus.out_ready_i[o];
        end
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_tail_o  = out_tail;
  assign bus.out_sel_o   = out_sel;
endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed and random checks of noc_switch_allocator against a
// packet-level reference model.
module tb_noc_switch_allocator;
  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         arst;
  logic [N-1:0] v, h, t, ordy;
  logic [N*N-1:0] pv;

  noc_switch_allocator_if #(.N_PORTS(N)) bus ();

  assign bus.in_valid_i  = v;
  assign bus.in_head_i   = h;
  assign bus.in_tail_i   = t;
  assign bus.in_port_i   = pv;
  assign bus.out_ready_i = ordy;

  noc_switch_allocator #(.N_PORTS(N)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int bnd [N];
  int ptr [N];

  logic [N-1:0]   e_rdy, e_val, e_tail;
  logic [N*N-1:0] e_sel;

  int rr_exp [12] = '{1, 2, 8, 1, 2, 8, 1, 2, 8, 1, 2, 8};
  int fl;
  int tailc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit owned(int i);
    for (int o = 0; o < N; o++) if (bnd[o] == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit wants(int i, int o);
    logic [N-1:0] p, lsb;
    p   = pv[i*N +: N];
    lsb = p & (~p + N'(1));
    return v[i] && h[i] && (lsb == N'(1 << o)) && !owned(i);
  endfunction

  task automatic model_out();
    int w;
    e_rdy = '0; e_val = '0; e_tail = '0; e_sel = '0;
    if (!arst) begin
      for (int o = 0; o < N; o++) begin
        if (bnd[o] >= 0) begin
          w = bnd[o];
          e_sel[o*N + w] = 1'b1;
          e_val[o]  = v[w];
          e_tail[o] = t[w];
          e_rdy[w]  = ordy[o];
        end
      end
    end
  endtask

  task automatic model_step();
    int nb [N];
    bit taken [N];
    int w, i;
    if (arst) begin
      for (int o = 0; o < N; o++) begin bnd[o] = -1; ptr[o] = 0; end
      return;
    end
    nb = bnd;
    for (int k = 0; k < N; k++) taken[k] = 1'b0;
    for (int o = 0; o < N; o++) begin
      if (bnd[o] >= 0) begin
        w = bnd[o];
        if (v[w] && ordy[o] && t[w]) nb[o] = -1;
      end else begin
        for (int k = 0; k < N; k++) begin
          i = (ptr[o] + k) % N;
          if (!taken[i] && wants(i, o)) begin
            nb[o] = i;
            ptr[o] = (i + 1) % N;
            taken[i] = 1'b1;
            break;
          end
        end
      end
    end
    bnd = nb;
  endtask

  task automatic settle();
    @(negedge clk);
    model_out();
    chk("in_ready", 32'(bus.in_ready_o), 32'(e_rdy));
    chk("out_valid", 32'(bus.out_valid_o), 32'(e_val));
    chk("out_tail", 32'(bus.out_tail_o), 32'(e_tail));
    chk("out_sel", 32'(bus.out_sel_o), 32'(e_sel));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear();
    v = '0; h = '0; t = '0; pv = '0; ordy = '1;
  endtask

  task automatic set_in(int i, bit vv, bit hh, bit tt, logic [N-1:0] p);
    v[i] = vv; h[i] = hh; t[i] = tt; pv[i*N +: N] = p;
  endtask

  initial begin
    for (int o = 0; o < N; o++) begin bnd[o] = -1; ptr[o] = 0; end
    clear();

    // reset with everything active
    arst = 1'b1;
    for (int i = 0; i < N; i++) set_in(i, 1, 1, 1, N'(1 << i));
    settle();
    chk("rst_sel0", 32'(bus.out_sel_o), 32'd0);
    tick();
    settle();
    chk("rst_rdy1", 32'(bus.in_ready_o), 32'd0);
    tick();
    arst = 1'b0;
    clear();
    set_in(2, 1, 1, 1, 5'b00001);
    settle();
    chk("post_rst_sel", 32'(bus.out_sel_o), 32'd0);
    tick();
    settle();
    chk("head_lat", 32'(bus.out_sel_o[4:0]), 32'b00100);
    tick();
    clear();

    // round robin on output 4
    set_in(0, 1, 1, 1, 5'b10000);
    set_in(1, 1, 1, 1, 5'b10000);
    set_in(3, 1, 1, 1, 5'b10000);
    settle();
    tick();
    for (int c = 0; c < 12; c++) begin
      settle();
      if (c % 2 == 0) chk("rr_owner", 32'(bus.out_sel_o[24:20]), 32'(rr_exp[c/2]));
      else            chk("rr_bubble", 32'(bus.out_sel_o[24:20]), 32'd0);
      tick();
    end
    clear();
    settle();
    tick();

    // packet locking on output 2
    fl = 0;
    tailc = -1;
    for (int c = 0; c < 9; c++) begin
      set_in(1, fl < 4, fl == 0, fl == 3, 5'b00100);
      if (c >= 1) set_in(4, 1, 1, 1, 5'b00100);
      ordy[2] = !(c == 2 || c == 3);
      settle();
      if (bus.in_ready_o[1] && v[1]) begin
        chk("lock_owner1", 32'(bus.out_sel_o[14:10]), 32'b00010);
        fl++;
        if (fl == 4) tailc = c;
      end
      if (c == 8) chk("lock_in4", 32'(bus.out_sel_o[14:10]), 32'b10000);
      tick();
    end
    chk("lock_flits", 32'(fl), 32'd4);
    chk("lock_tail_cyc", 32'(tailc), 32'd6);
    clear();
    settle();
    tick();

    // parallel crossbar traffic
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++)
        set_in(i, c < 4, c < 2, c == 3, N'(1 << (4 - i)));
      settle();
      if (c >= 1 && c <= 3) begin
        chk("par_sel", 32'(bus.out_sel_o),
            32'(25'b00001_00010_00100_01000_10000));
        chk("par_rdy", 32'(bus.in_ready_o), 32'b11111);
        chk("par_val", 32'(bus.out_valid_o), 32'b11111);
      end
      tick();
    end
    settle();
    chk("par_idle", 32'(bus.out_valid_o), 32'd0);
    tick();

    // malformed requests
    set_in(0, 1, 0, 0, 5'b00001);
    set_in(3, 1, 1, 0, 5'b00000);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("mal_rdy", 32'(bus.in_ready_o), 32'd0);
      chk("mal_sel", 32'(bus.out_sel_o), 32'd0);
      tick();
    end
    clear();

    // reset in the middle of a packet on output 4
    for (int c = 0; c < 7; c++) begin
      arst = (c == 3);
      set_in(0, 1, c < 2, c == 6, 5'b10000);
      settle();
      if (c >= 3) begin
        chk("mid_rdy", 32'(bus.in_ready_o[0]), 32'd0);
        chk("mid_val", 32'(bus.out_valid_o[4]), 32'd0);
      end
      tick();
    end
    arst = 1'b0;
    set_in(0, 1, 1, 1, 5'b10000);
    set_in(3, 1, 1, 1, 5'b10000);
    settle();
    tick();
    clear();
    settle();
    chk("mid_ptr0", 32'(bus.out_sel_o[24:20]), 32'b00001);
    tick();

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      arst = ($urandom_range(99) < 2);
      for (int i = 0; i < N; i++) begin
        int r;
        logic [N-1:0] p;
        r = $urandom_range(19);
        if (r == 0)      p = '0;
        else if (r == 1) p = N'($urandom_range(31));
        else             p = N'(1 << $urandom_range(N - 1));
        set_in(i, $urandom_range(99) < 70, $urandom_range(99) < 35,
               $urandom_range(99) < 40, p);
        ordy[i] = ($urandom_range(99) < 80);
      end
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_switch_allocator.md
# noc_switch_allocator

Per-output round-robin switch allocator for the NoC router. It sits between the per-input `input_router` instances and the crossbar. Each input presents a flit valid, head/tail flags and the one-hot output-port vector from its `input_router`. The allocator locks each output to one input for a whole packet (head to tail), drives the crossbar select, and gates the valid/ready handshakes on both sides.

## Interface
- `N_PORTS`, default 5: number of router ports. Input and output count are equal. Port order is the `router_port_o` bit order.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `arst`  in  1: reset. Synchronous and active-high; sampled on the `clk` rising edge.
- `in_valid_i`  in  N_PORTS: input i has a flit at its head.
- `in_head_i`  in  N_PORTS: flit on input i is a head flit.
- `in_tail_i`  in  N_PORTS: flit on input i is a tail flit. Head and tail both set means a single-flit packet.
- `in_port_i`  in  N_PORTS*N_PORTS: bits [i*N_PORTS +: N_PORTS] hold the one-hot destination of input i, as produced by `input_router` `router_port_o`.
- `in_ready_o`  out  N_PORTS: input i flit is accepted this cycle.
- `out_valid_o`  out  N_PORTS: output o carries a valid flit.
- `out_ready_i`  in  N_PORTS: downstream of output o accepts a flit.
- `out_sel_o`  out  N_PORTS*N_PORTS: bits [o*N_PORTS +: N_PORTS] are the one-hot crossbar select of output o; all zero when idle.
- `out_tail_o`  out  N_PORTS: the flit on output o is a tail flit (owner's `in_tail_i`).

## Operation
- Each output o has its own FSM with states IDLE and LOCKED, plus registers `owner[o]` (log2 N_PORTS bits) and `ptr[o]` (round-robin pointer).
- **Request.** Input i requests output o when `in_valid_i[i]`, `in_head_i[i]` and the decoded port of i equals o, and input i is not currently owned by any output.
- **Port decode.** Zero vector: no request. Multi-hot vector: only the lowest set bit is used.
- **IDLE.**
  - Search requesters starting at index `ptr[o]`, ascending, wrapping modulo N_PORTS.
  - The first hit i moves the FSM to LOCKED with `owner[o] = i` and `ptr[o] = (i+1) mod N_PORTS`.
  - With no hit, stay IDLE and leave `ptr` unchanged.
  - No flit transfers while IDLE.
- **LOCKED.**
  - `out_sel_o[o]` is one-hot at the owner.
  - `out_valid_o[o] = in_valid_i[owner]`.
  - `in_ready_o[owner] = out_ready_i[o]`.
  - `out_tail_o[o] = in_tail_i[owner]`.
- **Transfer.** A transfer is `in_valid_i[owner] & out_ready_i[o]`. A transfer with `in_tail_i[owner]` set returns the FSM to IDLE.
- **Inputs without ownership.**
  - `in_ready_o = 0`.
  - Non-head flits from such an input are ignored and never accepted.
  - An input can be owned by at most one output at a time.
- **Multi-output claims.** When two outputs would grant the same input in the same cycle (only possible with malformed vectors), the lower output index wins and the other stays IDLE.
- **Reset.**
  - All FSMs go to IDLE; `ptr` and `owner` go to 0.
  - All outputs are 0: `in_ready_o`, `out_valid_o`, `out_sel_o`, `out_tail_o`.
  - A packet in flight is abandoned. Reset dominates every other event in the same cycle.

## Timing
- Outputs are combinational from the FSM state registers and current inputs. There is no combinational path from `in_*` to the grant decision within the same cycle.
- **Head latency.** A head presented at cycle t with the output IDLE gives LOCKED at t+1, and the earliest transfer is at t+1.
- **Hold.** Stalls via `out_ready_i = 0` or `in_valid_i = 0` hold LOCKED indefinitely with no timeout.
- **Tail.** A tail transfer at cycle t gives IDLE at t+1; arbitration happens at t+1 and the next packet is LOCKED at t+2. Exactly one bubble cycle separates back-to-back packets on one output.
- **Single-flit packet.** LOCKED for exactly one cycle when `out_ready_i` is high.
- **Independence.** Outputs are fully independent. All N_PORTS outputs may transfer in the same cycle.

## Test plan
- **Reset.**
  - Stimulus: assert `arst` for 2 cycles with all inputs active.
  - Required: every output is 0 during reset and the cycle after. Then a head on input 2 to port 0 (`in_port_i[14:10] = 5'b00001`) gives `out_sel_o[4:0] = 5'b00100` one cycle later.
- **Round-robin.**
  - Stimulus: inputs 0, 1 and 3 continuously send single-flit packets to output 4, with `out_ready_i` all 1.
  - Required: owners sequence 0, 1, 3, 0, 1, 3. Each grant lasts 1 cycle with 1 bubble, giving one packet every 2 cycles.
- **Packet locking.**
  - Stimulus: input 1 sends a 4-flit packet to output 2 with `out_ready_i[2]` low in cycles 2–3. Input 4 sends a head to output 2 at cycle 1.
  - Required: input 4 waits until the input 1 tail transfers. It is locked 2 cycles after that tail, and all 4 input 1 flits appear on output 2 in order.
- **Parallelism.**
  - Stimulus: inputs 0–4 target outputs 4, 3, 2, 1, 0 respectively, all in the same cycle.
  - Required: all five outputs are LOCKED the next cycle, with five simultaneous transfers per cycle.
- **Malformed requests.**
  - Stimulus: input 0 sends a body flit with no lock, and input 3 sends a head with `in_port = 5'b00000`.
  - Required: `in_ready_o` stays 0 for both and no output locks.
- **Reset mid-packet.**
  - Stimulus: assert `arst` after the 2nd of 4 flits.
  - Required: output is IDLE next cycle, `ptr` is 0, and the remaining body flits of that input are not accepted.
